trig_sched: RTL and testbench
=============================

// Module: trig_sched
// PURPOSE
// - Trigger scheduler for the acquisition path. Takes NSRC single-cycle trigger pulses that have
//   already been moved into this clock domain by pulse-mode synchronizers, and grants one source
//   at a time using round-robin arbitration.
// - Emits one qualified trigger pulse with the winning source index, then enforces a programmable
//   holdoff. Supports one-shot or continuous re-arm and counts triggers lost during holdoff.
// PARAMETERS
// - NSRC  4   number of trigger sources, 2..16
// - HW    32  holdoff counter width
// - SW    $clog2(NSRC)  source index width (derived, localparam)
// PORTS
// - clk_i       in   1     clock; the only clock of this block
// - rstn_i      in   1     reset, asynchronous, active-low
// - src_pulse_i in   NSRC  trigger pulses, 1 cycle each, already in the clk_i domain
// - src_en_i    in   NSRC  per-source enable (level)
// - arm_i       in   1     arm request (pulse)
// - disarm_i    in   1     disarm/abort request (pulse)
// - single_i    in   1     1 = one-shot: go IDLE after holdoff; 0 = continuous: re-arm
// - holdoff_i   in   HW    holdoff length in cycles; sampled when a trigger is issued
// - trig_o      out  1     qualified trigger, 1-cycle pulse
// - trig_src_o  out  SW    index of the granted source; holds its value until the next grant
// - armed_o     out  1     state == ARMED
// - holdoff_o   out  1     state == HOLDOFF
// - pend_o      out  NSRC  pending-request register
// - miss_cnt_o  out  16    count of pulses lost during holdoff; saturates at 16'hFFFF
// BEHAVIOUR
// - Reset values:
//   - state IDLE; trig_o 0; trig_src_o 0; pend_o 0; miss_cnt_o 0; hold counter 0.
//   - Round-robin pointer last = NSRC-1, so source 0 wins the first tie.
// - FSM, IDLE:
//   - Pulses are ignored and not counted; pend stays 0.
//   - arm_i=1 -> ARMED on the next edge, and miss_cnt is cleared.
// - FSM, ARMED:
//   - Each cycle, pend[i] <= pend[i] | (src_pulse_i[i] & src_en_i[i]).
//   - If (pend & src_en_i) != 0, the grant is the first set bit found searching upward from
//     last+1, modulo NSRC. On the next edge:
//     - trig_o <= 1 and trig_src_o <= grant index;
//     - pend[grant] <= 0, while other pend bits are kept;
//     - last <= grant;
//     - hold counter cnt <= holdoff_i, and state -> HOLDOFF.
//   - Latency: a pulse at cycle t, with the block ARMED and no other pending request, gives
//     trig_o at cycle t+2.
// - FSM, HOLDOFF (occupies cycles T..T+holdoff, where trig_o=1 at cycle T):
//   - pend is not updated. Every enabled pulse is counted: miss_cnt += popcount(src_pulse_i &
//     src_en_i), saturating.
//   - If cnt==0: next state ARMED if single_i=0, else IDLE with pend cleared.
//     Otherwise cnt <= cnt-1.
//   - arm_i is ignored.
//   - Earliest next trigger is at T+holdoff+2, served from the retained pend bits.
// - trig_o is high for exactly one cycle per grant; it is never high in two consecutive cycles.
// - src_en_i[i]=0 clears pend[i] on the next edge in every state, and that source is never
//   granted.
// - disarm_i=1 in any state -> IDLE on the next edge:
//   - pend and cnt are cleared; no trig_o is issued.
//   - disarm_i beats arm_i and any simultaneous grant.
// - Multiple pulses in the same cycle:
//   - All are latched. They are served one per trigger, in round-robin order, with holdoff
//     between trigger pulses.
// - Asynchronous reset while running:
//   - All state returns to reset values immediately.
//   - trig_o drops without completing its cycle.
// TESTING
// - Case 1, single trigger:
//   - Reset, arm, holdoff_i=3, single_i=1.
//   - Pulse src 2 at cycle t -> trig_o at t+2 with trig_src_o=2; holdoff_o for 4 cycles; then
//     IDLE with armed_o=0.
// - Case 2, round-robin:
//   - Continuous mode, holdoff_i=0, all sources enabled.
//   - Pulse srcs 0,1,3 in the same cycle -> triggers at t+2, t+4, t+6 with sources 0,1,3.
// - Case 3, missed pulses:
//   - holdoff_i=10; pulse src 1, then 5 more src-1 pulses during holdoff.
//   - Expect miss_cnt_o=5 and only one trig_o.
//   - Re-arm from IDLE -> miss_cnt_o=0.
// - Case 4, enable masking:
//   - src_en_i=4'b1101. Pulse src 1 -> no trig_o and pend_o[1]=0.
//   - Latch src 3, then drop en[3] before its grant -> no trigger.
// - Case 5, disarm:
//   - Disarm in the same cycle as a pending grant, and again mid-holdoff.
//   - Expect no trig_o, next state IDLE, and pend_o=0.
//   - arm_i together with disarm_i -> stays IDLE.
// - Case 6, reset mid-operation:
//   - Assert rstn_i=0 during HOLDOFF with pend_o=4'b1000.
//   - All outputs go to 0 immediately. After re-arm and a new tie, source 0 wins first.

Source files
------------

// File: rtl/trig_sched_if.sv
`default_nettype none
// ============================================================================
// trig_sched_if : trigger source / qualified trigger bundle for trig_sched
// Rev 1.0
// ============================================================================
interface trig_sched_if #(
  parameter int NSRC = 4
);
  localparam int SW = $clog2(NSRC);

  logic [NSRC-1:0] src_pulse;
  logic [NSRC-1:0] src_en;
  logic            trig;
  logic [SW-1:0]   trig_src;

  modport master (
    output src_pulse,
    output src_en,
    input  trig,
    input  trig_src
  );

  modport slave (
    input  src_pulse,
    input  src_en,
    output trig,
    output trig_src
  );
endinterface
`default_nettype wire

// File: rtl/trig_sched.sv
`default_nettype none
// ============================================================================
// trig_sched : round-robin trigger scheduler with holdoff and miss counting
// Rev 1.0
// ============================================================================
module trig_sched #(
  parameter int NSRC = 4,
  parameter int HW   = 32
) (
  input  wire logic            clk_i,
  input  wire logic            rstn_i,
  trig_sched_if.slave          bus,
  input  wire logic            arm_i,
  input  wire logic            disarm_i,
  input  wire logic            single_i,
  input  wire logic [HW-1:0]   holdoff_i,
  output logic                 armed_o,
  output logic                 holdoff_o,
  output logic [NSRC-1:0]      pend_o,
  output logic [15:0]          miss_cnt_o
);
  localparam int SW = $clog2(NSRC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NSRC-1:0]   pend_q, pend_d;
  logic [SW-1:0]     last_q, last_d;
  logic [HW-1:0]     cnt_q, cnt_d;
  logic              trig_q, trig_d;
  logic [SW-1:0]     src_q, src_d;
  logic [15:0]       miss_q, miss_d;

  logic [NSRC-1:0]   req_w;
  logic [NSRC-1:0]   hits_w;
  logic              gnt_vld_w;
  logic [SW-1:0]     gnt_idx_w;
  logic [4:0]        pop_w;
  logic [16:0]       miss_sum_w;

  // Round-robin search: walk downward so the nearest source after last wins.
  always_comb begin
    req_w     = pend_q & bus.src_en;
    hits_w    = bus.src_pulse & bus.src_en;
    gnt_vld_w = 1'b0;
    gnt_idx_w = '0;
    for (int k = NSRC; k >= 1; k--) begin
      if (req_w[(int'(last_q) + k) % NSRC]) begin
        gnt_vld_w = 1'b1;
        gnt_idx_w = SW'((int'(last_q) + k) % NSRC);
      end
    end
    pop_w = '0;
    for (int i = 0; i < NSRC; i++) begin
      pop_w = pop_w + {4'b0, hits_w[i]};
    end
    miss_sum_w = {1'b0, miss_q} + {12'b0, pop_w};
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q & bus.src_en;
    last_d  = last_q;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;
    src_d   = src_q;
    miss_d  = miss_q;

    case (state_q)
      S_IDLE: begin
        pend_d = '0;
        if (arm_i) begin
          state_d = S_ARMED;
          miss_d  = '0;
        end
      end
      S_ARMED: begin
        pend_d = (pend_q | hits_w) & bus.src_en;
        if (gnt_vld_w) begin
          pend_d[gnt_idx_w] = 1'b0;
          trig_d            = 1'b1;
          src_d             = gnt_idx_w;
          last_d            = gnt_idx_w;
          cnt_d             = holdoff_i;
          state_d           = S_HOLD;
        end
      end
      S_HOLD: begin
        miss_d = miss_sum_w[16] ? 16'hFFFF : miss_sum_w[15:0];
        if (cnt_q == '0) begin
          if (single_i) begin
            state_d = S_IDLE;
            pend_d  = '0;
          end else begin
            state_d = S_ARMED;
          end
        end else begin
          cnt_d = cnt_q - HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any grant computed above in the same cycle.
    if (disarm_i) begin
      state_d = S_IDLE;
      pend_d  = '0;
      cnt_d   = '0;
      trig_d  = 1'b0;
      src_d   = src_q;
      last_d  = last_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      last_q  <= SW'(NSRC - 1);
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      src_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      src_q   <= src_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.trig     = trig_q;
  assign bus.trig_src = src_q;
  assign armed_o      = (state_q == S_ARMED);
  assign holdoff_o    = (state_q == S_HOLD);
  assign pend_o       = pend_q;
  assign miss_cnt_o   = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_trig_sched.sv
`default_nettype none
// ============================================================================
// tb_trig_sched : directed self-checking bench for trig_sched
// Rev 1.0
// ============================================================================
module tb_trig_sched;
  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        arm_i, disarm_i, single_i;
  logic [31:0] holdoff_i;
  logic        armed_o, holdoff_o;
  logic [3:0]  pend_o;
  logic [15:0] miss_cnt_o;

  int checks = 0;
  int errors = 0;
  int trig_seen;

  trig_sched_if #(.NSRC(4)) bus ();

  trig_sched #(.NSRC(4), .HW(32)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .bus        (bus),
    .arm_i      (arm_i),
    .disarm_i   (disarm_i),
    .single_i   (single_i),
    .holdoff_i  (holdoff_i),
    .armed_o    (armed_o),
    .holdoff_o  (holdoff_o),
    .pend_o     (pend_o),
    .miss_cnt_o (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i        = 1'b0;
    arm_i         = 1'b0;
    disarm_i      = 1'b0;
    single_i      = 1'b0;
    holdoff_i     = '0;
    bus.src_pulse = '0;
    bus.src_en    = 4'hF;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  task automatic arm();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    check("rst_trig",  bus.trig, 0);
    check("rst_src",   bus.trig_src, 0);
    check("rst_armed", armed_o, 0);
    check("rst_hold",  holdoff_o, 0);
    check("rst_pend",  pend_o, 0);
    check("rst_miss",  miss_cnt_o, 0);

    // ---------------- case 1: single trigger, one-shot, holdoff 3
    single_i  = 1'b1;
    holdoff_i = 32'd3;
    bus.src_pulse = 4'b0100;          // ignored while IDLE
    tick();
    bus.src_pulse = '0;
    check("c1_idle_pend", pend_o, 0);
    arm();
    check("c1_armed", armed_o, 1);
    bus.src_pulse = 4'b0100;
    tick();
    bus.src_pulse = '0;
    check("c1_t1_trig", bus.trig, 0);
    check("c1_t1_pend", pend_o, 4'b0100);
    tick();
    check("c1_t2_trig", bus.trig, 1);
    check("c1_t2_src",  bus.trig_src, 2);
    check("c1_t2_hold", holdoff_o, 1);
    check("c1_t2_pend", pend_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("c1_hold_on", holdoff_o, 1);
      check("c1_hold_trig", bus.trig, 0);
    end
    tick();
    check("c1_end_hold",  holdoff_o, 0);
    check("c1_end_armed", armed_o, 0);
    check("c1_src_held",  bus.trig_src, 2);

    // ---------------- case 2: round-robin, continuous, holdoff 0
    do_reset();
    single_i  = 1'b0;
    holdoff_i = 32'd0;
    arm();
    bus.src_pulse = 4'b1011;
    tick();
    bus.src_pulse = '0;
    check("c2_pend0", pend_o, 4'b1011);
    check("c2_trig_t1", bus.trig, 0);
    tick();
    check("c2_trigA", bus.trig, 1);
    check("c2_srcA",  bus.trig_src, 0);
    check("c2_pendA", pend_o, 4'b1010);
    tick();
    check("c2_gapA", bus.trig, 0);
    tick();
    check("c2_trigB", bus.trig, 1);
    check("c2_srcB",  bus.trig_src, 1);
    check("c2_pendB", pend_o, 4'b1000);
    tick();
    check("c2_gapB", bus.trig, 0);
    tick();
    check("c2_trigC", bus.trig, 1);
    check("c2_srcC",  bus.trig_src, 3);
    check("c2_pendC", pend_o, 0);
    tick();
    check("c2_after", bus.trig, 0);
    check("c2_rearm", armed_o, 1);

    // ---------------- case 3: missed pulses during holdoff 10
    do_reset();
    single_i  = 1'b1;
    holdoff_i = 32'd10;
    arm();
    bus.src_pulse = 4'b0010;
    tick();
    bus.src_pulse = '0;
    tick();
    check("c3_trig", bus.trig, 1);
    check("c3_src",  bus.trig_src, 1);
    trig_seen = 0;
    for (int i = 0; i < 5; i++) begin
      bus.src_pulse = 4'b0010;
      tick();
      bus.src_pulse = '0;
      if (bus.trig) trig_seen++;
      tick();
      if (bus.trig) trig_seen++;
    end
    check("c3_extra_trigs", trig_seen, 0);
    check("c3_hold_last", holdoff_o, 1);
    check("c3_pend_hold", pend_o, 0);
    check("c3_miss", miss_cnt_o, 5);
    tick();
    check("c3_idle", armed_o | holdoff_o, 0);
    check("c3_miss_idle", miss_cnt_o, 5);
    arm();
    check("c3_miss_clr", miss_cnt_o, 0);
    check("c3_rearmed", armed_o, 1);

    // ---------------- case 4: enable masking
    do_reset();
    single_i   = 1'b0;
    holdoff_i  = 32'd0;
    bus.src_en = 4'b1101;
    arm();
    bus.src_pulse = 4'b0010;
    tick();
    bus.src_pulse = '0;
    check("c4_masked_pend", pend_o, 0);
    tick();
    check("c4_masked_trig", bus.trig, 0);
    bus.src_pulse = 4'b1000;
    tick();
    bus.src_pulse = '0;
    bus.src_en    = 4'b0101;
    check("c4_latched", pend_o, 4'b1000);
    tick();
    check("c4_drop_trig", bus.trig, 0);
    check("c4_drop_pend", pend_o, 0);
    tick();
    check("c4_drop_trig2", bus.trig, 0);
    check("c4_still_armed", armed_o, 1);

    // ---------------- case 5: disarm
    do_reset();
    single_i  = 1'b0;
    holdoff_i = 32'd5;
    arm();
    bus.src_pulse = 4'b0001;
    tick();
    bus.src_pulse = '0;
    disarm_i = 1'b1;
    tick();
    disarm_i = 1'b0;
    check("c5a_trig",  bus.trig, 0);
    check("c5a_armed", armed_o, 0);
    check("c5a_hold",  holdoff_o, 0);
    check("c5a_pend",  pend_o, 0);
    arm();
    bus.src_pulse = 4'b0100;
    tick();
    bus.src_pulse = '0;
    tick();
    check("c5b_trig", bus.trig, 1);
    check("c5b_src",  bus.trig_src, 2);
    tick();
    check("c5b_hold", holdoff_o, 1);
    disarm_i = 1'b1;
    tick();
    disarm_i = 1'b0;
    check("c5b_hold_off", holdoff_o, 0);
    check("c5b_armed",    armed_o, 0);
    check("c5b_pend",     pend_o, 0);
    arm_i    = 1'b1;
    disarm_i = 1'b1;
    tick();
    arm_i    = 1'b0;
    disarm_i = 1'b0;
    check("c5c_armed", armed_o, 0);
    tick();
    check("c5c_trig", bus.trig, 0);

    // ---------------- case 6: asynchronous reset mid-operation
    do_reset();
    single_i  = 1'b0;
    holdoff_i = 32'd5;
    arm();
    bus.src_pulse = 4'b1001;
    tick();
    bus.src_pulse = '0;
    tick();
    check("c6_trig",  bus.trig, 1);
    check("c6_src",   bus.trig_src, 0);
    check("c6_pend",  pend_o, 4'b1000);
    check("c6_hold",  holdoff_o, 1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("c6_rst_trig", bus.trig, 0);
    check("c6_rst_src",  bus.trig_src, 0);
    check("c6_rst_pend", pend_o, 0);
    check("c6_rst_hold", holdoff_o, 0);
    check("c6_rst_arm",  armed_o, 0);
    check("c6_rst_miss", miss_cnt_o, 0);
    #2;
    rstn_i = 1'b1;
    tick();
    arm();
    bus.src_pulse = 4'b1001;
    tick();
    bus.src_pulse = '0;
    tick();
    check("c6_re_trig", bus.trig, 1);
    check("c6_re_src",  bus.trig_src, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
